ahbl_sram_excl: RTL and testbench
=================================

AHBL_SRAM_EXCL -- requirements
Module: ahbl_sram_excl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, size in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter N_WAIT, default 0, wait states inserted per data phase (0..7).
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset asynchronous and active-low.
REQ-005 SHALL have port ahbls_hready, input, 1 bit, bus-wide HREADY qualifying address-phase sampling.
REQ-006 SHALL have port ahbls_hready_resp, output, 1 bit, this slave's HREADYOUT.
REQ-007 SHALL have port ahbls_hresp, output, 1 bit, 1 = ERROR.
REQ-008 SHALL have port ahbls_hexokay, output, 1 bit, exclusive transfer success.
REQ-009 SHALL have ports ahbls_haddr (input, 32), ahbls_hwrite (input, 1), ahbls_htrans (input, 2), ahbls_hsize (input, 3), ahbls_hburst (input, 3), ahbls_hprot (input, 4), ahbls_hmastlock (input, 1), ahbls_hexcl (input, 1), with AHB5 meanings; hburst, hprot and hmastlock are ignored.
REQ-010 SHALL have ports ahbls_hwdata (input, 32) and ahbls_hrdata (output, 32).

Function
REQ-011 SHALL capture the address phase (addr, write, size, excl) only when ahbls_hready=1 and htrans[1]=1 (NONSEQ/SEQ); IDLE/BUSY SHALL produce a zero-wait OKAY with no side effects.
REQ-012 SHALL classify a captured transfer as an error when: word index >= DEPTH; or hsize > 2; or haddr misaligned to hsize.
REQ-013 SHALL implement states IDLE, WAIT, ERR1, ERR2.
REQ-014 On a valid capture: if N_WAIT = 0, go to IDLE (complete next cycle); else go to WAIT with counter = N_WAIT, with hready_resp=0 while the counter is nonzero, decrementing each cycle, and hready_resp=1 on the final cycle.
REQ-015 On an error capture: go to ERR1 (hready_resp=0, hresp=1), then ERR2 (hready_resp=1, hresp=1), with no memory write and no reservation change, regardless of N_WAIT.
REQ-016 SHALL hold hresp=0 in all states other than ERR1/ERR2.
REQ-017 SHALL write, on the final data-phase cycle, only the byte lanes selected by hsize and haddr[1:0] (little-endian) from ahbls_hwdata.
REQ-018 SHALL drive hrdata with the full addressed word on the final cycle of an OKAY read, and with 0 in all other cycles.
REQ-019 SHALL support back-to-back pipelined transfers: a new address phase sampled in the same cycle a data phase completes.
REQ-020 A read whose address phase coincides with completion of a write to the same word SHALL return the newly written data.
REQ-021 SHALL hold one reservation register (word address plus valid bit).
REQ-022 A successful exclusive read SHALL set the reservation to its word and drive hexokay=1 on its final cycle.
REQ-023 An exclusive write SHALL succeed only if the reservation is valid and matches the word. Success: write performed, hexokay=1, reservation cleared. Failure: no write, hexokay=0, hresp=0 (OKAY).
REQ-024 A non-exclusive write to the reserved word SHALL clear the reservation; non-exclusive writes to other words SHALL leave it unchanged.
REQ-025 hexokay SHALL be 0 in all cycles other than the final cycle of a successful exclusive transfer.
REQ-026 Memory contents SHALL be undefined after power-up and SHALL NOT be cleared by reset.

Reset
REQ-027 While rst_n=0, SHALL force state IDLE, hready_resp=1, hresp=0, hexokay=0, hrdata=0, wait counter 0, and reservation invalid, asynchronously.
REQ-028 Reset asserted mid-transfer SHALL abandon that transfer with no memory write.

Verification
REQ-029 N_WAIT=0: write word 0x8 = 0xDEADBEEF, then back-to-back read 0x8 -> hrdata 0xDEADBEEF in the cycle after the read address phase, hready_resp=1 throughout.
REQ-030 N_WAIT=2: read 0x0 -> hready_resp low for exactly 2 cycles, then high with data.
REQ-031 Halfword write 0xABCD at 0x12 over word 0x11223344 -> word 0x10 reads 0xABCD3344.
REQ-032 Read at DEPTH*4, or hsize=2 at 0x2 -> ERR1 (hready_resp=0, hresp=1) then ERR2 (hready_resp=1, hresp=1), memory unchanged.
REQ-033 Exclusive read 0x20, then exclusive write 0x20 -> hexokay=1 and data written. A second exclusive write to 0x20 -> hexokay=0 and no write.
REQ-034 Exclusive read 0x20, then plain write 0x20, then exclusive write 0x20 -> hexokay=0 and the plain-write value is retained. Formal: bench runs against the AHB-Lite master assumptions and slave assertions with no failures.

Source files
------------

// File: rtl/ahbl_sram_excl_if.sv
// AHB5-Lite slave bus bundle for the exclusive-access SRAM.
// The master modport covers the requester plus the interconnect that returns bus-wide HREADY.
interface ahbl_sram_excl_if;
  logic        hready;
  logic        hready_resp;
  logic        hresp;
  logic        hexokay;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic        hexcl;
  logic [31:0] hwdata;
  logic [31:0] hrdata;

  modport slave (
    input  hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
    output hready_resp, hresp, hexokay, hrdata
  );

  modport master (
    output hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
    input  hready_resp, hresp, hexokay, hrdata
  );
endinterface

// File: rtl/ahbl_sram_excl.sv
// AHB5-Lite SRAM slave with configurable wait states, two-cycle ERROR response and a
// single-entry exclusive-access monitor.
module ahbl_sram_excl #(
  parameter int DEPTH  = 1024,
  parameter int N_WAIT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  ahbl_sram_excl_if.slave  ahbls
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

  logic [31:0]   mem [DEPTH];

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          hready_resp_q;
  logic          hresp_q;
  logic          hexokay_q;
  logic [31:0]   hrdata_q;

  // Data-phase context of the transfer in flight.
  logic          fin_q;
  logic [AW-1:0] dp_idx_q;
  logic          dp_write_q;
  logic          dp_excl_q;
  logic [3:0]    dp_strb_q;
  logic          dp_wr_ok_q;

  logic          resv_valid_q;
  logic [AW-1:0] resv_idx_q;

  logic          cap;
  logic          a_err;
  logic [AW-1:0] a_idx;
  logic [3:0]    a_strb;

  logic          f_go;
  logic [AW-1:0] f_idx;
  logic          f_write;
  logic          f_excl;
  logic          resv_hit;
  logic          f_wr_ok;
  logic          wr_en;
  logic [31:0]   rd_word;

  logic          unused_ok;
  assign unused_ok = ^{ahbls.hburst, ahbls.hprot, ahbls.hmastlock};

  // Address-phase decode: lane strobes and error classification.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    cap    = ahbls.hready && ahbls.htrans[1];
    a_idx  = ahbls.haddr[AW+1:2];
    a_strb = 4'b0000;
    a_err  = (ahbls.haddr >> (AW + 2)) != 32'd0;
    case (ahbls.hsize)
      3'd0: a_strb = 4'b0001 << ahbls.haddr[1:0];
      3'd1: begin
        a_strb = 4'b0011 << {ahbls.haddr[1], 1'b0};
        a_err  = a_err || ahbls.haddr[0];
      end
      3'd2: begin
        a_strb = 4'b1111;
        a_err  = a_err || (ahbls.haddr[1:0] != 2'b00);
      end
      default: a_err = 1'b1;
    endcase
  end

  // Commit point: the edge that enters a transfer's final data-phase cycle. Without wait
  // states that is the capture edge itself, so the decision must use the live address bus.
  always_comb begin
    if (N_WAIT == 0) begin
      f_go    = hready_resp_q && cap && !a_err;
      f_idx   = a_idx;
      f_write = ahbls.hwrite;
      f_excl  = ahbls.hexcl;
    end else begin
      f_go    = (state_q == WAIT) && (cnt_q == 3'd1);
      f_idx   = dp_idx_q;
      f_write = dp_write_q;
      f_excl  = dp_excl_q;
    end
    resv_hit = resv_valid_q && (resv_idx_q == f_idx);
    f_wr_ok  = f_write && (!f_excl || resv_hit);
    wr_en    = fin_q && dp_wr_ok_q;
    // A write completing on this edge to the same word is forwarded lane by lane.
    rd_word  = mem[f_idx];
    for (int b = 0; b < 4; b++) begin
      if (wr_en && (dp_idx_q == f_idx) && dp_strb_q[b]) begin
        rd_word[8*b +: 8] = ahbls.hwdata[8*b +: 8];
      end
    end
  end

  // NOTE: the storage array has no reset; contents are undefined at power-up and survive
  // rst_n, and leaving it out of the reset tree lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (dp_strb_q[b]) mem[dp_idx_q][8*b +: 8] <= ahbls.hwdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      hready_resp_q <= 1'b1;
      hresp_q       <= 1'b0;
      hexokay_q     <= 1'b0;
      hrdata_q      <= 32'd0;
      fin_q         <= 1'b0;
      dp_idx_q      <= '0;
      dp_write_q    <= 1'b0;
      dp_excl_q     <= 1'b0;
      dp_strb_q     <= 4'b0000;
      dp_wr_ok_q    <= 1'b0;
      resv_valid_q  <= 1'b0;
      resv_idx_q    <= '0;
    end else begin
      hexokay_q <= 1'b0;
      hrdata_q  <= 32'd0;
      hresp_q   <= 1'b0;
      fin_q     <= 1'b0;

      if (f_go) begin
        fin_q      <= 1'b1;
        dp_wr_ok_q <= f_wr_ok;
        hexokay_q  <= f_excl && (!f_write || resv_hit);
        hrdata_q   <= f_write ? 32'd0 : rd_word;
        if (!f_write && f_excl) begin
          resv_valid_q <= 1'b1;
          resv_idx_q   <= f_idx;
        end else if (f_wr_ok && resv_hit) begin
          resv_valid_q <= 1'b0;
        end
      end

      if (hready_resp_q) begin
        // IDLE, ERR2 or the final WAIT cycle: the bus may present a new address phase.
        if (cap && a_err) begin
          state_q       <= ERR1;
          hready_resp_q <= 1'b0;
          hresp_q       <= 1'b1;
        end else if (cap) begin
          dp_idx_q   <= a_idx;
          dp_write_q <= ahbls.hwrite;
          dp_excl_q  <= ahbls.hexcl;
          dp_strb_q  <= a_strb;
          if (N_WAIT == 0) begin
            state_q       <= IDLE;
            hready_resp_q <= 1'b1;
          end else begin
            state_q       <= WAIT;
            cnt_q         <= 3'(N_WAIT);
            hready_resp_q <= 1'b0;
          end
        end else begin
          state_q       <= IDLE;
          hready_resp_q <= 1'b1;
        end
      end else if (state_q == ERR1) begin
        state_q       <= ERR2;
        hresp_q       <= 1'b1;
        hready_resp_q <= 1'b1;
      end else begin
        cnt_q         <= cnt_q - 3'd1;
        hready_resp_q <= (cnt_q == 3'd1);
      end
    end
  end

  assign ahbls.hready_resp = hready_resp_q;
  assign ahbls.hresp       = hresp_q;
  assign ahbls.hexokay     = hexokay_q;
  assign ahbls.hrdata      = hrdata_q;

endmodule

// File: tb/tb_ahbl_sram_excl.sv
// Directed bench: a zero-wait instance (b0/dut0) and a two-wait-state instance (b2/dut2),
// both 64 words deep, driven as a single AHB master each.
module tb_ahbl_sram_excl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  ahbl_sram_excl_if b0();
  ahbl_sram_excl_if b2();

  assign b0.hready = b0.hready_resp;
  assign b2.hready = b2.hready_resp;

  ahbl_sram_excl #(.DEPTH(64), .N_WAIT(0)) dut0 (.clk(clk), .rst_n(rst_n), .ahbls(b0));
  ahbl_sram_excl #(.DEPTH(64), .N_WAIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .ahbls(b2));

  // One complete transfer on b0; returns final-cycle outputs, hresp of the first data-phase
  // cycle and the number of low-HREADYOUT cycles (bounded).
  task automatic xfer0(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic ex, input logic [31:0] wd, output logic [31:0] rd,
                       output logic xok, output logic rsp, output logic rsp_first,
                       output int lows);
    @(negedge clk);
    b0.htrans = 2'b10; b0.haddr = addr; b0.hwrite = wr; b0.hsize = size; b0.hexcl = ex;
    @(negedge clk);
    b0.htrans = 2'b00; b0.hexcl = 1'b0; b0.hwdata = wd;
    rsp_first = b0.hresp;
    lows = 0;
    while (b0.hready_resp !== 1'b1 && lows < 8) begin
      lows++;
      @(negedge clk);
    end
    rd = b0.hrdata; xok = b0.hexokay; rsp = b0.hresp;
  endtask

  task automatic xfer2(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lows);
    @(negedge clk);
    b2.htrans = 2'b10; b2.haddr = addr; b2.hwrite = wr; b2.hsize = 3'd2; b2.hexcl = 1'b0;
    @(negedge clk);
    b2.htrans = 2'b00; b2.hwdata = wd;
    lows = 0;
    while (b2.hready_resp !== 1'b1 && lows < 8) begin
      lows++;
      @(negedge clk);
    end
    rd = b2.hrdata;
  endtask

  task automatic test_reset;
    total++;
    if ({b0.hready_resp, b0.hresp, b0.hexokay, b0.hrdata} !== {3'b100, 32'd0}) begin
      bad++;
      $display("FAIL reset_dut0: got rdy=%b resp=%b xok=%b rdata=%h want 1 0 0 0",
               b0.hready_resp, b0.hresp, b0.hexokay, b0.hrdata);
    end
    total++;
    if ({b2.hready_resp, b2.hresp, b2.hexokay, b2.hrdata} !== {3'b100, 32'd0}) begin
      bad++;
      $display("FAIL reset_dut2: got rdy=%b resp=%b xok=%b rdata=%h want 1 0 0 0",
               b2.hready_resp, b2.hresp, b2.hexokay, b2.hrdata);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    b0.htrans = 2'b10; b0.haddr = 32'h8; b0.hwrite = 1'b1; b0.hsize = 3'd2; b0.hexcl = 1'b0;
    @(negedge clk);
    b0.hwdata = 32'hDEADBEEF; b0.hwrite = 1'b0;
    total++;
    if (b0.hready_resp !== 1'b1) begin
      bad++; $display("FAIL b2b_wr_ready: got %b want 1", b0.hready_resp);
    end
    @(negedge clk);
    b0.htrans = 2'b00;
    total++;
    if ({b0.hready_resp, b0.hresp, b0.hrdata} !== {2'b10, 32'hDEADBEEF}) begin
      bad++;
      $display("FAIL b2b_rd: got rdy=%b resp=%b rdata=%h want 1 0 deadbeef",
               b0.hready_resp, b0.hresp, b0.hrdata);
    end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd;
    int lows;
    xfer2(1'b1, 32'h0, 32'hCAFEF00D, rd, lows);
    total++;
    if (lows !== 2) begin bad++; $display("FAIL wait_wr_lows: got %0d want 2", lows); end
    xfer2(1'b0, 32'h0, 32'h0, rd, lows);
    total++;
    if (lows !== 2 || rd !== 32'hCAFEF00D) begin
      bad++; $display("FAIL wait_rd: got lows=%0d rdata=%h want 2 cafef00d", lows, rd);
    end
    @(negedge clk);
    total++;
    if (b2.hrdata !== 32'd0) begin
      bad++; $display("FAIL wait_rdata_idle: got %h want 0", b2.hrdata);
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd; logic xok, rsp, rf; int lows;
    xfer0(1'b1, 32'h10, 3'd2, 1'b0, 32'h11223344, rd, xok, rsp, rf, lows);
    xfer0(1'b1, 32'h12, 3'd1, 1'b0, 32'hABCDFFFF, rd, xok, rsp, rf, lows);
    xfer0(1'b0, 32'h10, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'hABCD3344 || lows !== 0) begin
      bad++; $display("FAIL halfword: got %h lows=%0d want abcd3344 0", rd, lows);
    end
    xfer0(1'b1, 32'h11, 3'd0, 1'b0, 32'hEEEE55EE, rd, xok, rsp, rf, lows);
    xfer0(1'b0, 32'h10, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'hABCD5544) begin
      bad++; $display("FAIL byte: got %h want abcd5544", rd);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic xok, rsp, rf; int lows;
    xfer0(1'b1, 32'h0, 3'd2, 1'b0, 32'h01020304, rd, xok, rsp, rf, lows);
    xfer0(1'b0, 32'd256, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rf !== 1'b1 || lows !== 1 || rsp !== 1'b1 || rd !== 32'd0) begin
      bad++;
      $display("FAIL err_range: got first_resp=%b lows=%0d resp=%b rdata=%h want 1 1 1 0",
               rf, lows, rsp, rd);
    end
    xfer0(1'b1, 32'h2, 3'd2, 1'b0, 32'hFFFFFFFF, rd, xok, rsp, rf, lows);
    total++;
    if (rf !== 1'b1 || lows !== 1 || rsp !== 1'b1) begin
      bad++; $display("FAIL err_align: got first_resp=%b lows=%0d resp=%b want 1 1 1",
                      rf, lows, rsp);
    end
    xfer0(1'b1, 32'd256, 3'd2, 1'b0, 32'hFFFFFFFF, rd, xok, rsp, rf, lows);
    xfer0(1'b1, 32'h0, 3'd3, 1'b0, 32'hFFFFFFFF, rd, xok, rsp, rf, lows);
    total++;
    if (rsp !== 1'b1 || lows !== 1) begin
      bad++; $display("FAIL err_size: got resp=%b lows=%0d want 1 1", rsp, lows);
    end
    xfer0(1'b0, 32'h0, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'h01020304 || rsp !== 1'b0) begin
      bad++; $display("FAIL err_mem_kept: got %h resp=%b want 01020304 0", rd, rsp);
    end
  endtask

  task automatic test_idle_busy;
    logic [31:0] rd; logic xok, rsp, rf; int lows;
    @(negedge clk);
    b0.htrans = 2'b01; b0.haddr = 32'h0; b0.hwrite = 1'b1; b0.hsize = 3'd2;
    b0.hwdata = 32'hFFFFFFFF;
    @(negedge clk);
    b0.htrans = 2'b00;
    total++;
    if (b0.hready_resp !== 1'b1 || b0.hresp !== 1'b0) begin
      bad++; $display("FAIL busy_resp: got rdy=%b resp=%b want 1 0", b0.hready_resp, b0.hresp);
    end
    xfer0(1'b0, 32'h0, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'h01020304) begin
      bad++; $display("FAIL busy_no_write: got %h want 01020304", rd);
    end
  endtask

  task automatic test_exclusive;
    logic [31:0] rd; logic xok, rsp, rf; int lows;
    xfer0(1'b1, 32'h20, 3'd2, 1'b0, 32'h00000001, rd, xok, rsp, rf, lows);
    xfer0(1'b0, 32'h20, 3'd2, 1'b1, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (xok !== 1'b1 || rd !== 32'h1) begin
      bad++; $display("FAIL excl_rd: got xok=%b rdata=%h want 1 00000001", xok, rd);
    end
    xfer0(1'b1, 32'h20, 3'd2, 1'b1, 32'hA5A5A5A5, rd, xok, rsp, rf, lows);
    total++;
    if (xok !== 1'b1 || rsp !== 1'b0) begin
      bad++; $display("FAIL excl_wr_ok: got xok=%b resp=%b want 1 0", xok, rsp);
    end
    xfer0(1'b0, 32'h20, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'hA5A5A5A5 || xok !== 1'b0) begin
      bad++; $display("FAIL excl_wr_data: got %h xok=%b want a5a5a5a5 0", rd, xok);
    end
    xfer0(1'b1, 32'h20, 3'd2, 1'b1, 32'h5A5A5A5A, rd, xok, rsp, rf, lows);
    total++;
    if (xok !== 1'b0 || rsp !== 1'b0) begin
      bad++; $display("FAIL excl_wr_second: got xok=%b resp=%b want 0 0", xok, rsp);
    end
    xfer0(1'b0, 32'h20, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'hA5A5A5A5) begin
      bad++; $display("FAIL excl_second_no_write: got %h want a5a5a5a5", rd);
    end
  endtask

  task automatic test_excl_plain;
    logic [31:0] rd; logic xok, rsp, rf; int lows;
    xfer0(1'b0, 32'h20, 3'd2, 1'b1, 32'h0, rd, xok, rsp, rf, lows);
    xfer0(1'b1, 32'h20, 3'd2, 1'b0, 32'h12345678, rd, xok, rsp, rf, lows);
    xfer0(1'b1, 32'h20, 3'd2, 1'b1, 32'h0BADF00D, rd, xok, rsp, rf, lows);
    total++;
    if (xok !== 1'b0 || rsp !== 1'b0) begin
      bad++; $display("FAIL plain_clears_resv: got xok=%b resp=%b want 0 0", xok, rsp);
    end
    xfer0(1'b0, 32'h20, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'h12345678) begin
      bad++; $display("FAIL plain_value_kept: got %h want 12345678", rd);
    end
    // Plain write to another word and an errored exclusive read leave the reservation.
    xfer0(1'b0, 32'h20, 3'd2, 1'b1, 32'h0, rd, xok, rsp, rf, lows);
    xfer0(1'b1, 32'h24, 3'd2, 1'b0, 32'h77777777, rd, xok, rsp, rf, lows);
    xfer0(1'b0, 32'd256, 3'd2, 1'b1, 32'h0, rd, xok, rsp, rf, lows);
    xfer0(1'b1, 32'h20, 3'd2, 1'b1, 32'h600DF00D, rd, xok, rsp, rf, lows);
    total++;
    if (xok !== 1'b1) begin
      bad++; $display("FAIL other_word_keeps_resv: got xok=%b want 1", xok);
    end
    xfer0(1'b0, 32'h20, 3'd2, 1'b1, 32'h0, rd, xok, rsp, rf, lows);
    xfer0(1'b1, 32'h24, 3'd2, 1'b1, 32'h99999999, rd, xok, rsp, rf, lows);
    total++;
    if (xok !== 1'b0) begin
      bad++; $display("FAIL excl_wrong_word: got xok=%b want 0", xok);
    end
    xfer0(1'b0, 32'h24, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'h77777777) begin
      bad++; $display("FAIL excl_wrong_word_data: got %h want 77777777", rd);
    end
  endtask

  task automatic test_reset_mid_transfer;
    logic [31:0] rd; logic xok, rsp, rf; int lows;
    xfer0(1'b0, 32'h20, 3'd2, 1'b1, 32'h0, rd, xok, rsp, rf, lows);
    xfer2(1'b1, 32'h30, 32'h11111111, rd, lows);
    @(negedge clk);
    b2.htrans = 2'b10; b2.haddr = 32'h30; b2.hwrite = 1'b1; b2.hsize = 3'd2;
    @(negedge clk);
    b2.htrans = 2'b00; b2.hwdata = 32'h22222222;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (b2.hready_resp !== 1'b1 || b2.hresp !== 1'b0) begin
      bad++; $display("FAIL async_reset: got rdy=%b resp=%b want 1 0", b2.hready_resp, b2.hresp);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    xfer2(1'b0, 32'h30, 32'h0, rd, lows);
    total++;
    if (rd !== 32'h11111111) begin
      bad++; $display("FAIL reset_abandons_write: got %h want 11111111", rd);
    end
    xfer0(1'b0, 32'h10, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'hABCD5544) begin
      bad++; $display("FAIL mem_survives_reset: got %h want abcd5544", rd);
    end
    xfer0(1'b1, 32'h20, 3'd2, 1'b1, 32'h0, rd, xok, rsp, rf, lows);
    xfer0(1'b0, 32'h20, 3'd2, 1'b0, 32'h0, rd, xok, rsp, rf, lows);
    total++;
    if (rd !== 32'h600DF00D) begin
      bad++; $display("FAIL reset_clears_resv: got %h want 600df00d", rd);
    end
  endtask

  initial begin
    b0.htrans = 2'b00; b0.haddr = '0; b0.hwrite = 1'b0; b0.hsize = 3'd2; b0.hexcl = 1'b0;
    b0.hburst = 3'd0; b0.hprot = 4'h3; b0.hmastlock = 1'b0; b0.hwdata = '0;
    b2.htrans = 2'b00; b2.haddr = '0; b2.hwrite = 1'b0; b2.hsize = 3'd2; b2.hexcl = 1'b0;
    b2.hburst = 3'd0; b2.hprot = 4'h3; b2.hmastlock = 1'b0; b2.hwdata = '0;
    repeat (3) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    test_back_to_back;
    test_wait_states;
    test_byte_lanes;
    test_errors;
    test_idle_busy;
    test_exclusive;
    test_excl_plain;
    test_reset_mid_transfer;
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
